// File: rtl/decoder_nto2n_seq_pkg.sv
// Shared encodings for the sequenced N-to-2^N decoder: mode field and scan direction.
package decoder_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Smallest counter width able to hold 0..div-1; never below one bit.
  function automatic int cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/decoder_nto2n_seq_prescaler.sv
// Scan-step prescaler: ticks once every DIV enabled, non-cleared cycles.
module step_prescaler
  import decoder_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Tick is combinational so the step lands on the same edge the count reaches LAST.
  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (en) begin
      if (clr || tick) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with load/clear/hold and a prescaled scan walker.
module decoder_nto2n_seq
  import decoder_pkg::*;
#(
  parameter  int SEL_W    = 2,
  parameter  int SCAN_DIV = 1,
  localparam int OUT_W    = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             dir,
  output logic [OUT_W-1:0] m,
  output logic [SEL_W-1:0] idx,
  output logic             valid,
  output logic             wrap
);

  localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

  logic             tick;
  logic [SEL_W-1:0] idx_n;
  logic             vld_n;
  logic             wrap_n;

  // Any mode other than SCAN abandons the partial count.
  step_prescaler #(.DIV(SCAN_DIV)) u_pre (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (en),
    .clr    (mode != MODE_SCAN),
    .tick   (tick)
  );

  always_comb begin
    idx_n  = idx;
    vld_n  = valid;
    wrap_n = 1'b0;
    case (mode)
      MODE_LOAD: begin
        idx_n = sel;
        vld_n = 1'b1;
      end
      MODE_CLEAR: begin
        idx_n = '0;
        vld_n = 1'b0;
      end
      MODE_SCAN: begin
        if (tick) begin
          vld_n = 1'b1;
          if (!valid) begin
            // Entering the walk from all-zero starts at the end matching the direction.
            idx_n = (dir == DIR_DN) ? '1 : '0;
          end else if (dir == DIR_UP) begin
            idx_n  = idx + 1'b1;
            wrap_n = (idx == '1);
          end else begin
            idx_n  = idx - 1'b1;
            wrap_n = (idx == '0);
          end
        end
      end
      default: ;
    endcase
  end

  // m is decoded from the next index and registered with it, so m == valid ? 1<<idx : 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx   <= '0;
      valid <= 1'b0;
      m     <= '0;
      wrap  <= 1'b0;
    end else if (en) begin
      idx   <= idx_n;
      valid <= vld_n;
      m     <= vld_n ? (ONE << idx_n) : '0;
      wrap  <= wrap_n;
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Bench: three decoder configurations driven in lockstep against a behavioural model.
module tb_decoder_nto2n_seq;
  import decoder_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n, en, dir;
  logic [1:0] mode;
  logic [2:0] sel;

  logic [3:0] m0, m1;
  logic [7:0] m2;
  logic [1:0] i0, i1;
  logic [2:0] i2;
  logic       v0, v1, v2, w0, w1, w2;

  always #5 clk = ~clk;

  decoder_nto2n_seq #(.SEL_W(2), .SCAN_DIV(1)) u0 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .sel(sel[1:0]), .dir(dir),
    .m(m0), .idx(i0), .valid(v0), .wrap(w0));
  decoder_nto2n_seq #(.SEL_W(2), .SCAN_DIV(3)) u1 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .sel(sel[1:0]), .dir(dir),
    .m(m1), .idx(i1), .valid(v1), .wrap(w1));
  decoder_nto2n_seq #(.SEL_W(3), .SCAN_DIV(2)) u2 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .sel(sel), .dir(dir),
    .m(m2), .idx(i2), .valid(v2), .wrap(w2));

  int npass = 0;
  int nchk  = 0;

  // Reference model: position of the lit bit as a plain integer, plus a step counter.
  int ow[3] = '{4, 4, 8};
  int dv[3] = '{1, 3, 2};
  int r_idx[3];
  int r_cnt[3];
  bit r_vld[3];
  bit r_wrap[3];

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      r_idx[k] = 0; r_cnt[k] = 0; r_vld[k] = 0; r_wrap[k] = 0;
    end
  endfunction

  function automatic void model_edge();
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      r_wrap[k] = 0;
      if (!en) continue;
      if (mode == MODE_SCAN) begin
        if (r_cnt[k] == dv[k] - 1) begin
          r_cnt[k] = 0;
          if (!r_vld[k]) begin
            r_idx[k] = dir ? ow[k] - 1 : 0;
            r_vld[k] = 1;
          end else if (!dir) begin
            r_wrap[k] = (r_idx[k] == ow[k] - 1);
            r_idx[k]  = (r_idx[k] + 1) % ow[k];
          end else begin
            r_wrap[k] = (r_idx[k] == 0);
            r_idx[k]  = (r_idx[k] + ow[k] - 1) % ow[k];
          end
        end else begin
          r_cnt[k]++;
        end
      end else begin
        r_cnt[k] = 0;
        if (mode == MODE_LOAD) begin
          r_idx[k] = int'(sel) % ow[k];
          r_vld[k] = 1;
        end else if (mode == MODE_CLEAR) begin
          r_idx[k] = 0;
          r_vld[k] = 0;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic check_all(input string tag);
    logic [31:0] gm, gi, gv, gw;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin gm = 32'(m0); gi = 32'(i0); gv = 32'(v0); gw = 32'(w0); end
        1:       begin gm = 32'(m1); gi = 32'(i1); gv = 32'(v1); gw = 32'(w1); end
        default: begin gm = 32'(m2); gi = 32'(i2); gv = 32'(v2); gw = 32'(w2); end
      endcase
      chk($sformatf("%s.u%0d.m", tag, k), gm, r_vld[k] ? (32'd1 << r_idx[k]) : 32'd0);
      chk($sformatf("%s.u%0d.idx", tag, k), gi, 32'(r_idx[k]));
      chk($sformatf("%s.u%0d.valid", tag, k), gv, 32'(r_vld[k]));
      chk($sformatf("%s.u%0d.wrap", tag, k), gw, 32'(r_wrap[k]));
    end
  endtask

  task automatic cyc(input bit e, input bit [1:0] md, input bit [2:0] s, input bit d,
                     input string tag);
    en = e; mode = md; sel = s; dir = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  // Reset asserted between edges must clear outputs before any clock arrives.
  task automatic async_pulse(input string tag);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all(tag);
    @(negedge clk);
    check_all({tag, "_held"});
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1; mode = MODE_SCAN; sel = 3'd5; dir = 1'b0;
    model_reset();

    // Reset with arbitrary inputs
    repeat (3) cyc(1'($urandom), 2'($urandom), 3'($urandom), 1'($urandom), "rst");
    chk("rst_m0", 32'(m0), 32'd0);
    reset_n = 1'b1;

    // LOAD sweep
    for (int s = 0; s < 4; s++) cyc(1, MODE_LOAD, 3'(s), 0, $sformatf("load%0d", s));
    chk("load3_m0", 32'(m0), 32'h8);

    // Scan up from zero, single-cycle step
    cyc(1, MODE_CLEAR, 0, 0, "t3_clr");
    for (int i = 0; i < 5; i++) cyc(1, MODE_SCAN, 0, DIR_UP, $sformatf("t3_scan%0d", i));
    chk("t3_m0", 32'(m0), 32'h1);
    chk("t3_wrap0", 32'(w0), 32'd1);

    // Prescaled scan down, with en low mid-count
    cyc(1, MODE_LOAD, 0, 0, "t4_load");
    cyc(1, MODE_SCAN, 0, DIR_DN, "t4_s1");
    cyc(0, MODE_SCAN, 0, DIR_DN, "t4_en0a");
    cyc(0, MODE_SCAN, 0, DIR_DN, "t4_en0b");
    cyc(1, MODE_SCAN, 0, DIR_DN, "t4_s2");
    chk("t4_m1_pre", 32'(m1), 32'h1);
    cyc(1, MODE_SCAN, 0, DIR_DN, "t4_s3");
    chk("t4_m1", 32'(m1), 32'h8);
    chk("t4_wrap1", 32'(w1), 32'd1);
    cyc(1, MODE_SCAN, 0, DIR_UP, "t4_dirflip");

    // CLEAR then HOLD
    cyc(1, MODE_LOAD, 2, 0, "t5_load");
    cyc(1, MODE_CLEAR, 2, 0, "t5_clr");
    chk("t5_v0", 32'(v0), 32'd0);
    cyc(1, MODE_HOLD, 3, 0, "t5_hold1");
    cyc(1, MODE_HOLD, 1, 1, "t5_hold2");
    chk("t5_m0", 32'(m0), 32'd0);

    // Async reset mid-scan, then LOAD of the top index
    cyc(1, MODE_LOAD, 1, 0, "t6_load");
    cyc(1, MODE_SCAN, 0, DIR_UP, "t6_s1");
    cyc(1, MODE_SCAN, 0, DIR_UP, "t6_s2");
    async_pulse("t6_async");
    chk("t6_m2_rst", 32'(m2), 32'd0);
    cyc(1, MODE_LOAD, 7, 0, "t6_load7");
    chk("t6_m2", 32'(m2), 32'h80);
    chk("t6_m0", 32'(m0), 32'h8);

    // Randomized traffic, SCAN-heavy
    for (int i = 0; i < 400; i++) begin
      bit [1:0] md;
      int r = $urandom_range(0, 9);
      md = (r < 5) ? MODE_SCAN : 2'(r - 5);
      if ($urandom_range(0, 59) == 0) async_pulse($sformatf("rnd%0d_rst", i));
      cyc(($urandom_range(0, 7) != 0), md, 3'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
